// File: rtl/pipelined_cla_subtractor.sv
// Pipelined unsigned subtractor: A - B computed as A + ~B + 1 with one
// carry-lookahead slice per register stage, returning {borrow, diff}.
module pipelined_cla_subtractor #(
  parameter int WIDTH   = 16,
  parameter int STAGE_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_sub1,
  input  logic [WIDTH-1:0] i_sub2,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH:0]   o_result,
  output logic             o_borrow
);

  localparam int NSTG = (STAGE_W > 0) ? (WIDTH / STAGE_W) : 1;

  if (STAGE_W < 1 || (WIDTH % STAGE_W) != 0) begin : g_bad_params
    $error("pipelined_cla_subtractor: WIDTH must be a positive multiple of STAGE_W");
  end

  // Handshake: an operand pair transfers on a rising edge where i_valid & o_ready;
  // a result transfers where o_valid & i_ready. The whole pipe advances together
  // when the output register is empty or being drained (adv = !o_valid | i_ready),
  // so o_ready never depends on i_valid.

  // Flattened lookahead: every carry is a sum of G/P product terms back to cin.
  // Returns {carry_out, sum}.
  function automatic logic [STAGE_W:0] cla_slice(
    input logic [STAGE_W-1:0] a,
    input logic [STAGE_W-1:0] b_inv,
    input logic               cin
  );
    logic [STAGE_W-1:0] g;
    logic [STAGE_W-1:0] p;
    logic [STAGE_W-1:0] sum;
    logic [STAGE_W:0]   c;
    logic               prop;
    g    = a & b_inv;
    p    = a | b_inv;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < STAGE_W; i++) begin
      c[i+1] = g[i];
      prop   = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (prop & g[j]);
        prop   = prop & p[j];
      end
      c[i+1] = c[i+1] | (prop & cin);
    end
    sum = a ^ b_inv ^ c[STAGE_W-1:0];
    return {c[STAGE_W], sum};
  endfunction

  logic             adv;
  logic             vld_q  [NSTG];
  logic             vld_d  [NSTG];
  logic [WIDTH-1:0] a_q    [NSTG];
  logic [WIDTH-1:0] a_d    [NSTG];
  logic [WIDTH-1:0] b_q    [NSTG];
  logic [WIDTH-1:0] b_d    [NSTG];
  logic [WIDTH-1:0] diff_q [NSTG];
  logic [WIDTH-1:0] diff_d [NSTG];
  // Carry is kept inverted (as a borrow) so the all-zero reset state reads as result 0.
  logic             bor_q  [NSTG];
  logic             bor_d  [NSTG];
  logic [STAGE_W:0] slice_res [NSTG];

  assign adv     = !o_valid | i_ready;
  assign o_ready = adv;

  always_comb begin
    slice_res[0] = cla_slice(i_sub1[STAGE_W-1:0], ~i_sub2[STAGE_W-1:0], 1'b1);
    for (int k = 1; k < NSTG; k++) begin
      slice_res[k] = cla_slice(a_q[k-1][k*STAGE_W +: STAGE_W],
                               ~b_q[k-1][k*STAGE_W +: STAGE_W],
                               ~bor_q[k-1]);
    end
  end

  always_comb begin
    for (int k = 0; k < NSTG; k++) begin
      vld_d[k]  = vld_q[k];
      a_d[k]    = a_q[k];
      b_d[k]    = b_q[k];
      diff_d[k] = diff_q[k];
      bor_d[k]  = bor_q[k];
    end
    if (adv) begin
      vld_d[0]                    = i_valid;
      a_d[0]                      = i_sub1;
      b_d[0]                      = i_sub2;
      diff_d[0]                   = '0;
      diff_d[0][STAGE_W-1:0]      = slice_res[0][STAGE_W-1:0];
      bor_d[0]                    = ~slice_res[0][STAGE_W];
      for (int k = 1; k < NSTG; k++) begin
        vld_d[k]                      = vld_q[k-1];
        a_d[k]                        = a_q[k-1];
        b_d[k]                        = b_q[k-1];
        diff_d[k]                     = diff_q[k-1];
        diff_d[k][k*STAGE_W +: STAGE_W] = slice_res[k][STAGE_W-1:0];
        bor_d[k]                      = ~slice_res[k][STAGE_W];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NSTG; k++) begin
        vld_q[k]  <= 1'b0;
        a_q[k]    <= '0;
        b_q[k]    <= '0;
        diff_q[k] <= '0;
        bor_q[k]  <= 1'b0;
      end
    end else begin
      for (int k = 0; k < NSTG; k++) begin
        vld_q[k]  <= vld_d[k];
        a_q[k]    <= a_d[k];
        b_q[k]    <= b_d[k];
        diff_q[k] <= diff_d[k];
        bor_q[k]  <= bor_d[k];
      end
    end
  end

  assign o_valid  = vld_q[NSTG-1];
  assign o_result = {bor_q[NSTG-1], diff_q[NSTG-1]};
  assign o_borrow = bor_q[NSTG-1];

endmodule

// File: tb/tb_pipelined_cla_subtractor.sv
// Scoreboard bench for pipelined_cla_subtractor: directed vectors, streaming,
// backpressure, bubbles, async reset and randomized traffic against A-B arithmetic.
module tb_pipelined_cla_subtractor;
  localparam int W = 16;
  localparam int S = 4;
  localparam int N = W / S;
  typedef logic [W:0] res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_valid = 1'b0;
  logic         i_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         o_ready;
  logic         o_valid;
  logic         o_borrow;
  logic [W:0]   o_result;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   rdy_mode = 1;
  bit   mon_en = 1'b0;
  bit   lat_chk = 1'b0;
  logic [W:0] exp_q[$];
  int   acc_q[$];

  pipelined_cla_subtractor #(.WIDTH(W), .STAGE_W(S)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_sub1(a), .i_sub2(b), .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_borrow(o_borrow)
  );

  // clock/reset block
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    return res_t'({1'b0, x}) - res_t'({1'b0, y});
  endfunction

  task automatic check(input string name, input res_t act, input res_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // driver tasks
  task automatic send_exp(input logic [W-1:0] x, input logic [W-1:0] y, input res_t e);
    int guard;
    guard   = 0;
    i_valid = 1'b1;
    a       = x;
    b       = y;
    @(negedge clk);
    while (!o_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!o_ready) begin
      check("accept_timeout", res_t'(o_ready), res_t'(1));
      i_valid = 1'b0;
      return;
    end
    exp_q.push_back(e);
    acc_q.push_back(cyc);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
    send_exp(x, y, model(x, y));
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    rdy_mode = 1;
    while (exp_q.size() != 0 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    check("drain_timeout", res_t'(exp_q.size()), '0);
    @(posedge clk);
    #1;
  endtask

  // downstream ready driver
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       i_ready = 1'b0;
      1:       i_ready = 1'b1;
      default: i_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (rst_n && mon_en) begin
      check("ready_rule", res_t'(o_ready), res_t'(!o_valid | i_ready));
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", o_result, 'x);
        end else begin
          check("result", o_result, exp_q[0]);
          check("borrow", res_t'(o_borrow), res_t'(exp_q[0][W]));
          if (i_ready) begin
            if (lat_chk) check("gap_latency", res_t'(cyc - acc_q[0]), res_t'(N));
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    logic [W-1:0] dir_a [6] = '{16'h1234, 16'h0000, 16'h0000, 16'hFFFF, 16'h1000, 16'hABCD};
    logic [W-1:0] dir_b [6] = '{16'h0234, 16'h0001, 16'hFFFF, 16'h0000, 16'h0001, 16'hABCD};
    res_t         dir_e [6] = '{17'h01000, 17'h1FFFF, 17'h10001, 17'h0FFFF, 17'h00FFF, 17'h00000};
    int lat;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", res_t'(o_valid), '0);
    check("rst_result", o_result, '0);
    check("rst_borrow", res_t'(o_borrow), '0);
    check("rst_ready", res_t'(o_ready), res_t'(1));
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // basic latency
    send_exp(dir_a[0], dir_b[0], dir_e[0]);
    lat = 1;
    while (!o_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", res_t'(lat), res_t'(N));
    drain();

    // directed vectors with hand-computed results
    for (int i = 1; i < 6; i++) begin
      send_exp(dir_a[i], dir_b[i], dir_e[i]);
      idle($urandom_range(0, 1));
    end
    drain();

    // streaming: 8 back-to-back -> 8 consecutive valid cycles
    fork
      begin
        for (int i = 0; i < 8; i++) send(W'($urandom), W'($urandom));
      end
      begin
        int g;
        g = 0;
        @(negedge clk);
        while (!o_valid && g < 50) begin
          @(negedge clk);
          g++;
        end
        for (int i = 0; i < 8; i++) begin
          check("stream_valid", res_t'(o_valid), res_t'(1));
          @(negedge clk);
        end
      end
    join
    drain();

    // backpressure: fill the pipe, stall 5 cycles with a pending input
    rdy_mode = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) send(W'($urandom), W'($urandom));
    fork
      send(16'h8000, 16'h7FFF);
      begin
        repeat (5) begin
          @(negedge clk);
          check("bp_ready", res_t'(o_ready), '0);
          check("bp_valid", res_t'(o_valid), res_t'(1));
        end
        rdy_mode = 1;
      end
    join
    drain();

    // bubbles with ready held high: gaps must be preserved
    lat_chk = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send(W'($urandom), W'($urandom));
      idle($urandom_range(0, 3));
    end
    drain();
    lat_chk = 1'b0;

    // async reset mid-stream
    for (int i = 0; i < 3; i++) send(W'($urandom), W'($urandom));
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", res_t'(o_valid), '0);
    check("arst_result", o_result, '0);
    check("arst_borrow", res_t'(o_borrow), '0);
    exp_q.delete();
    acc_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    check("arst_ready", res_t'(o_ready), res_t'(1));
    idle(10);

    // randomized traffic with random backpressure
    rdy_mode = 2;
    for (int i = 0; i < 1000; i++) begin
      send(W'($urandom), W'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
